// File: rtl/aes_pkg.sv
// Shared AES definitions for the SubBytes engine.
//   SBOX / INV_SBOX : FIPS-197 forward and inverse substitution tables
//   sb_state_e      : engine FSM states
//   lanes_legal()   : true when a LANES value divides the 16-byte state evenly
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sb_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Only powers of two up to 16 split the state into whole beats.
  function automatic bit lanes_legal(int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane.
//   data_i : byte to substitute
//   inv_i  : 1 selects the inverse table (only honoured when INV_EN=1)
//   data_o : substituted byte
module aes_sbox_lane
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [7:0] data_i,
  input  logic       inv_i,
  output logic [7:0] data_o
);

  generate
    if (INV_EN) begin : g_fwd_inv
      assign data_o = inv_i ? INV_SBOX[data_i] : SBOX[data_i];
    end else begin : g_fwd_only
      // Inverse table is not referenced here, so it is never built.
      logic unused_inv;
      assign unused_inv = inv_i;
      assign data_o     = SBOX[data_i];
    end
  endgenerate

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes engine: substitutes LANES bytes of a 128-bit state
// per clock, in place, over BEATS = 16/LANES cycles.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   in_valid_i/in_ready_o    : input handshake (ready only in IDLE)
//   in_state_i, in_inv_i     : state (byte i = bits [8i+7:8i]) and inverse select
//   out_valid_o/out_ready_i  : output handshake (valid only in DONE)
//   out_state_o              : substituted state, straight from the working register
//   busy_o                   : operation in progress or result pending
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter bit INV_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_state_i,
  input  logic         in_inv_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_state_o,
  output logic         busy_o
);

  localparam int BEATS = 16 / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES=%0d is not one of 1, 2, 4, 8, 16", LANES);
    end
  endgenerate

  sb_state_e          state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               mode_reg, mode_next;
  logic [127:0]       work_reg, work_next;

  logic [3:0]         lane_idx [LANES];
  logic [7:0]         lane_in  [LANES];
  logic [7:0]         lane_out [LANES];

  // Lane gi of beat cnt works on byte cnt*LANES+gi; the product never exceeds 15.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_idx[gi] = 4'(int'(cnt_reg) * LANES + gi);
      assign lane_in[gi]  = work_reg[8*lane_idx[gi] +: 8];

      aes_sbox_lane #(
        .INV_EN (INV_EN)
      ) u_lane (
        .data_i (lane_in[gi]),
        .inv_i  (mode_reg),
        .data_o (lane_out[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    work_next  = work_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid_i) begin
          work_next  = in_state_i;
          mode_next  = INV_EN ? in_inv_i : 1'b0;
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int li = 0; li < LANES; li++) begin
          work_next[8*lane_idx[li] +: 8] = lane_out[li];
        end
        if (cnt_reg == CNT_W'(BEATS - 1)) begin
          cnt_next   = '0;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      work_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      work_reg  <= work_next;
    end
  end

  // Ready is masked while reset is held so nothing is offered during reset,
  // and rises as soon as reset is released.
  assign in_ready_o  = rst_ni && (state_reg == ST_IDLE);
  assign out_valid_o = (state_reg == ST_DONE);
  assign busy_o      = (state_reg == ST_RUN) || (state_reg == ST_DONE);
  assign out_state_o = work_reg;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench: six engines share one stimulus stream (LANES 1,2,4,8,16 with INV_EN=1,
// plus LANES=4 with INV_EN=0). Expected states come from a GF(2^8) model of
// the S-box (multiplicative inverse + affine map), not from lookup tables.
module tb_sub_bytes_engine;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_ready;
  logic [N-1:0] in_ready;
  logic [N-1:0] out_valid;
  logic [N-1:0] busy;
  logic [127:0] out_state [N];

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      localparam int L = (gi < 5) ? (1 << gi) : 4;
      sub_bytes_engine #(
        .LANES  (L),
        .INV_EN (gi < 5)
      ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready[gi]),
        .in_state_i  (in_state),
        .in_inv_i    (in_inv),
        .out_valid_o (out_valid[gi]),
        .out_ready_i (out_ready),
        .out_state_o (out_state[gi]),
        .busy_o      (busy[gi])
      );
    end
  endgenerate

  function automatic int lanes_of(int i);
    return (i < 5) ? (1 << i) : 4;
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_model(logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    if (x == 8'h00) r = 8'h00;
    else for (int k = 0; k < 254; k++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(logic [127:0] s, logic inv);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) begin
      r[8*b +: 8] = inv ? ref_inv[s[8*b +: 8]] : ref_fwd[s[8*b +: 8]];
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction through all engines. hold_cycles>0 keeps out_ready low in DONE.
  task automatic run_txn(input logic [127:0] st, input logic inv, input int hold_cycles);
    int            lat [N];
    logic [127:0]  exp;
    logic [127:0]  snap [N];
    int            w;
    w = 0;
    @(negedge clk);
    while (in_ready !== {N{1'b1}} && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_val("ready_wait", 128'(in_ready), 128'({N{1'b1}}));
    in_valid = 1'b1;
    in_state = st;
    in_inv   = inv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = ~inv;
    for (int i = 0; i < N; i++) lat[i] = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (out_valid[i] && lat[i] == 0) lat[i] = c;
    end
    @(negedge clk);
    check_val("busy_done", 128'(busy), 128'({N{1'b1}}));
    check_val("ready_done", 128'(in_ready), 128'(0));
    for (int i = 0; i < N; i++) begin
      exp = ref_sub(st, (i < 5) ? inv : 1'b0);
      check_val($sformatf("lat_l%0d_i%0d", lanes_of(i), i), 128'(lat[i]), 128'(16 / lanes_of(i)));
      check_val($sformatf("data_l%0d_i%0d", lanes_of(i), i), out_state[i], exp);
      snap[i] = out_state[i];
    end
    $display("txn state=%h inv=%0d -> l4=%h", st, inv, out_state[2]);
    for (int c = 0; c < hold_cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) check_val($sformatf("hold_data_i%0d", i), out_state[i], snap[i]);
      check_val("hold_ready", 128'(in_ready), 128'(0));
      check_val("hold_valid", 128'(out_valid), 128'({N{1'b1}}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_val("valid_after_take", 128'(out_valid), 128'(0));
    check_val("ready_after_take", 128'(in_ready), 128'({N{1'b1}}));
  endtask

  initial begin
    logic rose;
    logic [127:0] st;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    for (int x = 0; x < 256; x++) begin
      ref_fwd[x] = sbox_model(8'(x));
      ref_inv[ref_fwd[x]] = 8'(x);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", 128'(out_valid), 128'(0));
    check_val("rst_busy", 128'(busy), 128'(0));
    check_val("rst_ready", 128'(in_ready), 128'(0));
    for (int i = 0; i < N; i++) check_val($sformatf("rst_state_i%0d", i), out_state[i], 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("ready_after_rst", 128'(in_ready), 128'({N{1'b1}}));

    // Directed cases.
    run_txn(128'h53, 1'b0, 0);
    @(negedge clk);
    check_val("fwd_53_const", out_state[2], 128'h6363636363636363636363636363_63ED);
    run_txn({16{8'h63}}, 1'b1, 0);
    run_txn({16{8'hED}}, 1'b1, 0);
    run_txn(128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 0);
    check_val("sweep_const", out_state[0], 128'h76ABD7FE2B670130C56F6BF27B777C63);
    run_txn(128'h0, 1'b1, 0);
    check_val("inv_en0_const", out_state[5], {16{8'h63}});
    run_txn({$urandom, $urandom, $urandom, $urandom}, 1'b0, 10);

    // Randomized traffic.
    for (int t = 0; t < 12; t++) begin
      run_txn({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 0);
    end

    // Reset while the LANES=1 engine is at beat 7.
    @(negedge clk);
    in_valid = 1'b1;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rose  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid[0]) rose = 1'b1;
    end
    check_val("abort_valid", 128'(rose), 128'(0));
    check_val("abort_state", out_state[0], 128'(0));
    check_val("abort_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rose  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid[0]) rose = 1'b1;
    end
    check_val("abort_no_result", 128'(rose), 128'(0));
    st = {$urandom, $urandom, $urandom, $urandom};
    run_txn(st, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 SHALL have parameter LANES, default 4: S-box lanes per beat; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have parameter INV_EN, default 1: 1 = inverse S-box mode available; 0 = forward only.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid_i, input, 1: input state offered.
REQ-006 SHALL have port in_ready_o, output, 1: engine can accept a state.
REQ-007 SHALL have port in_state_i, input, 128: state; byte i = bits [8i+7:8i].
REQ-008 SHALL have port in_inv_i, input, 1: 1 = InvSubBytes; sampled with in_state_i.
REQ-009 SHALL have port out_valid_o, output, 1: result available.
REQ-010 SHALL have port out_ready_i, input, 1: consumer takes result.
REQ-011 SHALL have port out_state_o, output, 128: substituted state, same byte order as input.
REQ-012 SHALL have port busy_o, output, 1: high in RUN or DONE.

Function
REQ-013 SHALL implement FSM IDLE, RUN, DONE; BEATS = 16/LANES.
REQ-014 In IDLE, SHALL drive in_ready_o=1; in RUN and DONE, in_ready_o=0.
- Accept = in_valid_i & in_ready_o.
- On accept: capture in_state_i into working register, latch mode, clear beat counter, go to RUN.
REQ-015 In RUN, each cycle SHALL substitute bytes [cnt*LANES .. cnt*LANES+LANES-1] in place, then increment cnt.
REQ-016 After beat BEATS-1, SHALL go to DONE.
- out_valid_o SHALL rise BEATS cycles after the accept edge.
- Latency: LANES=16 -> 1 cycle; LANES=1 -> 16 cycles.
REQ-017 In DONE, SHALL hold out_valid_o=1 and out_state_o stable until out_ready_i=1.
- That edge returns to IDLE with out_valid_o=0.
- in_ready_o SHALL be 1 on the following cycle.
- No input is accepted while DONE.
REQ-018 SHALL source out_state_o directly from the working register, with no combinational path from inputs.
- Value SHALL be final only in DONE.
REQ-019 SHALL use the FIPS-197 forward S-box when latched mode=0 and the FIPS-197 inverse S-box when mode=1.
REQ-020 With INV_EN=0, SHALL ignore in_inv_i, force mode to forward, and not synthesise the inverse table.
REQ-021 SHALL wrap the beat counter, clog2(BEATS) bits (min 1), at BEATS-1; the counter SHALL never index beyond byte 15.
REQ-022 SHALL ignore in_valid_i outside IDLE; an in_valid_i held through RUN is accepted only after return to IDLE.
REQ-023 SHALL ignore out_ready_i outside DONE.

Reset
REQ-024 While rst_ni=0 at a clock edge, SHALL reset as follows:
- state=IDLE, cnt=0, mode=0, working register=0.
- out_valid_o=0, out_state_o=0, busy_o=0, in_ready_o=0.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation with no result emitted.
REQ-026 in_ready_o SHALL be 1 in the first cycle after rst_ni returns high.

Structure
REQ-027 Shared package aes_pkg SHALL hold:
- SBOX[256] and INV_SBOX[256] constant tables;
- the FSM state enum;
- the LANES legality check.
REQ-028 SHALL instantiate sub-module aes_sbox_lane LANES times: 8-bit in, 8-bit out, inv select, parameter INV_EN; purely combinational.
REQ-029 SHALL raise an elaboration error for an illegal LANES.

Verification
REQ-030 Forward single byte: LANES=4, state with byte 0=0x53, others 0x00, inv=0 -> byte 0=0xED, others 0x63; out_valid_o 4 cycles after accept.
REQ-031 Inverse round trip: all bytes 0x63, inv=1 -> all bytes 0x00; then feed 0xED..ED, inv=1 -> all 0x53.
REQ-032 Latency sweep: LANES in {1,2,4,8,16}, state 0x000102...0F -> 0x637C777BF26B6FC53001672BFED7AB76 (byte 0=0x63); out_valid_o at 16/8/4/2/1 cycles.
REQ-033 Backpressure: hold out_ready_i=0 for 10 cycles in DONE -> out_state_o stable, in_ready_o=0; release -> in_ready_o=1 next cycle.
REQ-034 Reset mid-RUN: LANES=1, rst_ni=0 at beat 7 -> out_valid_o never rises, out_state_o=0; next accepted state processed correctly.
REQ-035 INV_EN=0: in_inv_i=1 with all bytes 0x00 -> all bytes 0x63 (forward forced).
